ldpc_mem_port_ctrl: RTL and testbench

//  Requester-side controller for the team's single-port synchronous-read/write message RAM.
//  It arbitrates write and read requests from the LDPC decoder datapath onto the one RAM port.
//  It absorbs the 1-cycle RAM read latency and returns read data over a valid/ready response channel.
//  It provides a synthesizable sequential clear (zero-fill) of the whole RAM.

---
 rtl/ldpc_mem_port_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ldpc_mem_port_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_mem_port_ctrl.sv
// ldpc_mem_port_ctrl
//   Requester-side controller for a single-port synchronous RAM holding LDPC messages.
//   Arbitrates decoder write/read requests onto the one RAM port, absorbs the 1-cycle
//   read latency into a 2-entry response FIFO, and runs a sequential zero-fill clear.
//
// Ports
//   clk, reset                 clock (posedge) and asynchronous active-high reset
//   i_clr_start                pulse: start zero-fill (only honoured in ACCESS)
//   o_clr_busy / o_clr_done    clear in progress / pulse on final clear write
//   i_wr_valid/o_wr_ready      write request handshake, i_wr_addr/i_wr_data payload
//   i_rd_valid/o_rd_ready      read request handshake, i_rd_addr payload
//   o_rsp_valid/i_rsp_ready    read response handshake, o_rsp_data = FIFO head
//   o_ram_*                    RAM address/data_in/we/cs, combinational from this cycle's op
//   i_ram_data_out             RAM read data, valid the cycle after a read issue
module ldpc_mem_port_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clr_start,
    output logic                  o_clr_busy,
    output logic                  o_clr_done,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_valid,
    output logic                  o_rd_ready,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic [ADDR_WIDTH-1:0] o_ram_address,
    output logic [DATA_WIDTH-1:0] o_ram_data_in,
    output logic                  o_ram_we,
    output logic                  o_ram_cs,
    input  logic [DATA_WIDTH-1:0] i_ram_data_out
);

    typedef enum logic [0:0] {
        StAccess,
        StClear
    } state_e;

    // Counter is one bit wider than the address so it never wraps before the last word.
    localparam logic [ADDR_WIDTH:0] LastClrAddr = (ADDR_WIDTH + 1)'(RAM_DEPTH - 1);

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_WIDTH:0]   r_clr_cnt;
    logic [ADDR_WIDTH:0]   w_clr_cnt_next;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_fifo [2];
    logic                  r_fifo_wr_ptr;
    logic                  r_fifo_rd_ptr;
    logic [1:0]            r_fifo_occ;

    logic w_run;
    logic w_access;
    logic w_clearing;
    logic w_clr_last;
    logic w_push;
    logic w_pop;
    logic w_credit;
    logic w_wr_fire;
    logic w_rd_fire;

    // Outputs are forced low while reset is held, independent of the clock.
    assign w_run      = !reset;
    assign w_access   = w_run && (r_state == StAccess);
    assign w_clearing = w_run && (r_state == StClear);
    assign w_clr_last = (r_clr_cnt == LastClrAddr);

    assign o_rsp_valid = w_run && (r_fifo_occ != 2'd0);
    assign o_rsp_data  = r_fifo[r_fifo_rd_ptr];

    assign w_push = r_inflight;
    assign w_pop  = o_rsp_valid && i_rsp_ready;

    // A read may issue only if its response is guaranteed a FIFO slot; a pop this cycle
    // frees one in time for the response two cycles later.
    assign w_credit = (({1'b0, r_fifo_occ} + {2'b00, r_inflight}) < 3'd2) || w_pop;

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        o_clr_busy     = 1'b0;
        o_clr_done     = 1'b0;
        o_wr_ready     = 1'b0;
        o_rd_ready     = 1'b0;
        o_ram_cs       = 1'b0;
        o_ram_we       = 1'b0;
        o_ram_address  = '0;
        o_ram_data_in  = '0;
        w_wr_fire      = 1'b0;
        w_rd_fire      = 1'b0;

        if (w_access) begin
            o_wr_ready = !i_clr_start;
            o_rd_ready = !i_clr_start && !i_wr_valid && w_credit;
            w_wr_fire  = i_wr_valid && o_wr_ready;
            w_rd_fire  = i_rd_valid && o_rd_ready;
            if (i_clr_start) begin
                w_state_next   = StClear;
                w_clr_cnt_next = '0;
            end else if (w_wr_fire) begin
                o_ram_cs      = 1'b1;
                o_ram_we      = 1'b1;
                o_ram_address = i_wr_addr;
                o_ram_data_in = i_wr_data;
            end else if (w_rd_fire) begin
                o_ram_cs      = 1'b1;
                o_ram_address = i_rd_addr;
            end
        end else if (w_clearing) begin
            o_clr_busy     = 1'b1;
            o_ram_cs       = 1'b1;
            o_ram_we       = 1'b1;
            o_ram_address  = r_clr_cnt[ADDR_WIDTH-1:0];
            o_clr_done     = w_clr_last;
            w_clr_cnt_next = r_clr_cnt + 1'b1;
            if (w_clr_last) begin
                w_state_next = StAccess;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StAccess;
            r_clr_cnt  <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_clr_cnt  <= w_clr_cnt_next;
            r_inflight <= w_rd_fire;
        end
    end

    // 2-entry response FIFO; push comes from the read issued in the previous cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fifo[0]     <= '0;
            r_fifo[1]     <= '0;
            r_fifo_wr_ptr <= 1'b0;
            r_fifo_rd_ptr <= 1'b0;
            r_fifo_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_fifo_wr_ptr] <= i_ram_data_out;
                r_fifo_wr_ptr         <= !r_fifo_wr_ptr;
            end
            if (w_pop) begin
                r_fifo_rd_ptr <= !r_fifo_rd_ptr;
            end
            if (w_push && !w_pop) begin
                r_fifo_occ <= r_fifo_occ + 2'd1;
            end else if (!w_push && w_pop) begin
                r_fifo_occ <= r_fifo_occ - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ldpc_mem_port_ctrl.sv
// tb_ldpc_mem_port_ctrl
//   Directed bench for ldpc_mem_port_ctrl with ADDR_WIDTH=4, DATA_WIDTH=8, driving a
//   behavioural single-port synchronous RAM. Inputs change on the falling edge and
//   outputs are sampled 1 ns later, well away from the rising edge.
module tb_ldpc_mem_port_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    logic          clk;
    logic          reset;
    logic          i_clr_start;
    logic          o_clr_busy;
    logic          o_clr_done;
    logic          i_wr_valid;
    logic          o_wr_ready;
    logic [AW-1:0] i_wr_addr;
    logic [DW-1:0] i_wr_data;
    logic          i_rd_valid;
    logic          o_rd_ready;
    logic [AW-1:0] i_rd_addr;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_data;
    logic [AW-1:0] o_ram_address;
    logic [DW-1:0] o_ram_data_in;
    logic          o_ram_we;
    logic          o_ram_cs;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] ram_mem [16];

    int n_checks = 0;
    int n_pass   = 0;

    ldpc_mem_port_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .i_clr_start   (i_clr_start),
        .o_clr_busy    (o_clr_busy),
        .o_clr_done    (o_clr_done),
        .i_wr_valid    (i_wr_valid),
        .o_wr_ready    (o_wr_ready),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .i_rd_valid    (i_rd_valid),
        .o_rd_ready    (o_rd_ready),
        .i_rd_addr     (i_rd_addr),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_data    (o_rsp_data),
        .o_ram_address (o_ram_address),
        .o_ram_data_in (o_ram_data_in),
        .o_ram_we      (o_ram_we),
        .o_ram_cs      (o_ram_cs),
        .i_ram_data_out(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM, preloaded with 0xFF so the clear is observable.
    initial begin
        for (int i = 0; i < 16; i++) ram_mem[i] = 8'hFF;
        ram_dout = '0;
    end

    always @(posedge clk) begin
        if (o_ram_cs) begin
            if (o_ram_we) ram_mem[o_ram_address] <= o_ram_data_in;
            else          ram_dout <= ram_mem[o_ram_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        i_clr_start = 1'b0;
        i_wr_valid  = 1'b0;
        i_rd_valid  = 1'b0;
        i_wr_addr   = '0;
        i_wr_data   = '0;
        i_rd_addr   = '0;
    endtask

    // One write cycle, assumed accepted immediately.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        idle_inputs();
        i_wr_valid = 1'b1;
        i_wr_addr  = a;
        i_wr_data  = d;
        #1;
        chk("wr_issue_cs", {o_ram_cs, o_ram_we}, 2'b11);
        chk("wr_issue_addr", o_ram_address, a);
        chk("wr_issue_data", o_ram_data_in, d);
    endtask

    logic [DW-1:0] exp_rd [8];

    initial begin
        reset       = 1'b1;
        i_rsp_ready = 1'b1;
        idle_inputs();
        #2;
        chk("rst_busy", o_clr_busy, 1'b0);
        chk("rst_done", o_clr_done, 1'b0);
        chk("rst_ready", {o_wr_ready, o_rd_ready}, 2'b00);
        chk("rst_rsp_valid", o_rsp_valid, 1'b0);
        chk("rst_ram_ctl", {o_ram_cs, o_ram_we}, 2'b00);

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {o_wr_ready, o_rd_ready}, 2'b11);
        chk("post_rst_ram_cs", o_ram_cs, 1'b0);

        // Full clear; clr_start held during the first CLEAR cycle must be ignored.
        @(negedge clk);
        i_clr_start = 1'b1;
        i_wr_valid  = 1'b1;
        #1;
        chk("clr_start_ready", {o_wr_ready, o_rd_ready}, 2'b00);
        chk("clr_start_no_op", o_ram_cs, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            i_clr_start = (i == 0);
            i_wr_valid  = 1'b0;
            #1;
            chk("clr_busy", o_clr_busy, 1'b1);
            chk("clr_ctl", {o_ram_cs, o_ram_we}, 2'b11);
            chk("clr_addr", o_ram_address, i);
            chk("clr_data", o_ram_data_in, 0);
            chk("clr_done", o_clr_done, (i == 15));
            chk("clr_ready", {o_wr_ready, o_rd_ready}, 2'b00);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("clr_end_busy", o_clr_busy, 1'b0);
        chk("clr_end_done", o_clr_done, 1'b0);

        // Write 0x5A to addr 3, then read it: response two cycles after issue.
        do_write(4'd3, 8'h5A);
        @(negedge clk);
        idle_inputs();
        i_rd_valid = 1'b1;
        i_rd_addr  = 4'd3;
        #1;
        chk("rd3_ready", o_rd_ready, 1'b1);
        chk("rd3_ctl", {o_ram_cs, o_ram_we}, 2'b10);
        chk("rd3_addr", o_ram_address, 4'd3);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("rd3_n1_valid", o_rsp_valid, 1'b0);
        @(negedge clk);
        #1;
        chk("rd3_n2_valid", o_rsp_valid, 1'b1);
        chk("rd3_n2_data", o_rsp_data, 8'h5A);
        @(negedge clk);
        #1;
        chk("rd3_n3_valid", o_rsp_valid, 1'b0);

        // Back-to-back reads of addrs 0..7 after clear plus the 0x5A write.
        for (int i = 0; i < 8; i++) exp_rd[i] = (i == 3) ? 8'h5A : 8'h00;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            idle_inputs();
            i_rd_valid = (c < 8);
            i_rd_addr  = c[AW-1:0];
            #1;
            if (c < 8) chk("b2b_rd_ready", o_rd_ready, 1'b1);
            if (c >= 2 && c < 10) begin
                chk("b2b_rsp_valid", o_rsp_valid, 1'b1);
                chk("b2b_rsp_data", o_rsp_data, exp_rd[c-2]);
            end
            if (c == 10) chk("b2b_drained", o_rsp_valid, 1'b0);
        end

        // Backpressure: only two reads accepted while rsp_ready=0.
        do_write(4'd8, 8'h11);
        do_write(4'd9, 8'h22);
        do_write(4'd10, 8'h33);
        i_rsp_ready = 1'b0;
        @(negedge clk);
        idle_inputs();
        i_rd_valid = 1'b1;
        i_rd_addr  = 4'd8;
        #1;
        chk("bp_c0_ready", o_rd_ready, 1'b1);
        @(negedge clk);
        i_rd_addr = 4'd9;
        #1;
        chk("bp_c1_ready", o_rd_ready, 1'b1);
        @(negedge clk);
        i_rd_addr = 4'd10;
        #1;
        chk("bp_c2_ready", o_rd_ready, 1'b0);
        chk("bp_c2_ctl", o_ram_cs, 1'b0);
        chk("bp_c2_data", {o_rsp_valid, o_rsp_data}, {1'b1, 8'h11});
        @(negedge clk);
        #1;
        chk("bp_c3_ready", o_rd_ready, 1'b0);
        chk("bp_c3_hold", {o_rsp_valid, o_rsp_data}, {1'b1, 8'h11});
        @(negedge clk);
        i_rsp_ready = 1'b1;
        #1;
        chk("bp_c4_ready", o_rd_ready, 1'b1);
        chk("bp_c4_data", {o_rsp_valid, o_rsp_data}, {1'b1, 8'h11});
        @(negedge clk);
        idle_inputs();
        #1;
        chk("bp_c5_data", {o_rsp_valid, o_rsp_data}, {1'b1, 8'h22});
        @(negedge clk);
        #1;
        chk("bp_c6_data", {o_rsp_valid, o_rsp_data}, {1'b1, 8'h33});
        @(negedge clk);
        #1;
        chk("bp_c7_valid", o_rsp_valid, 1'b0);

        // Same-cycle write and read to addr 5: write first, read sees new data.
        @(negedge clk);
        idle_inputs();
        i_wr_valid = 1'b1;
        i_wr_addr  = 4'd5;
        i_wr_data  = 8'hA7;
        i_rd_valid = 1'b1;
        i_rd_addr  = 4'd5;
        #1;
        chk("wr_rd_rd_ready", o_rd_ready, 1'b0);
        chk("wr_rd_wr_ctl", {o_ram_cs, o_ram_we}, 2'b11);
        chk("wr_rd_wr_data", o_ram_data_in, 8'hA7);
        @(negedge clk);
        i_wr_valid = 1'b0;
        #1;
        chk("wr_rd_rd_issue", {o_rd_ready, o_ram_cs, o_ram_we}, 3'b110);
        chk("wr_rd_rd_addr", o_ram_address, 4'd5);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        #1;
        chk("wr_rd_rsp", {o_rsp_valid, o_rsp_data}, {1'b1, 8'hA7});

        // Reset in the middle of a clear, at address 7, then restart.
        @(negedge clk);
        i_clr_start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            i_clr_start = 1'b0;
            #1;
        end
        chk("mid_clr_addr", o_ram_address, 4'd7);
        reset = 1'b1;
        #1;
        chk("mid_clr_rst_busy", o_clr_busy, 1'b0);
        chk("mid_clr_rst_ctl", {o_ram_cs, o_ram_we, o_clr_done}, 3'b000);
        chk("mid_clr_rst_ready", {o_wr_ready, o_rd_ready, o_rsp_valid}, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("after_rst_access", {o_clr_busy, o_wr_ready}, 2'b01);
        i_clr_start = 1'b1;
        @(negedge clk);
        i_clr_start = 1'b0;
        #1;
        chk("restart_busy", o_clr_busy, 1'b1);
        chk("restart_addr", o_ram_address, 4'd0);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            #1;
        end
        chk("restart_done", {o_clr_done, o_ram_address}, {1'b1, 4'd15});
        @(negedge clk);
        #1;
        chk("restart_end", o_clr_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
